bscan_byte_bridge: RTL and testbench

Protocol stage between the BSCANE2 USER4 TAP signals and the puzzle solver. It deserializes 8-bit DR scans (LSB first) into bytes and buffers them in a small first-word-fall-through FIFO with a valid/ready handshake toward the solver. On every DR capture it loads the solver's result into a shift register and serializes it out on `tdo`. It is the upstream feeder of every day's solver and the downstream consumer of its result.

---
 rtl/bscan_byte_bridge.sv | 151 +++++++++++++++
 tb/tb_bscan_byte_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bscan_byte_bridge.sv
// bscan_byte_bridge
//   Bridge between the BSCANE2 USER4 TAP signals and a solver core.
//   Inbound: 8-bit DR scans (LSB first) are deserialized and pushed into a
//   small first-word-fall-through FIFO presented as a valid/ready stream.
//   Outbound: every DR capture loads the solver result into a shift register
//   that is serialized LSB first on tdo.
//
// Ports
//   tck            : only clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   tdi            : serial data from the TAP, valid while shift_dr
//   tdo            : serial result toward the TAP (straight from a flop)
//   ir_is_user     : IR holds USER4; gates every TAP-driven action
//   capture_dr     : TAP in Capture-DR this cycle
//   shift_dr       : TAP in Shift-DR this cycle
//   update_dr      : TAP in Update-DR this cycle
//   inbound_valid  : FIFO head byte available
//   inbound_ready  : solver accepts the head byte this cycle
//   inbound_data   : FIFO head byte
//   result_valid   : result is final
//   result         : solver answer, RESULT_WIDTH bits
//   overflow       : sticky, a completed byte was dropped on a full FIFO

module bscan_byte_bridge #(
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    output logic                    inbound_valid,
    input  logic                    inbound_ready,
    output logic [7:0]              inbound_data,
    input  logic                    result_valid,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic                    overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       BIT_MAX  = 4'd15;
    localparam logic [3:0]       BYTE_LEN = 4'd8;

    // TAP-side state
    logic [7:0]              in_sr;
    logic [3:0]              bit_cnt;
    logic [RESULT_WIDTH-1:0] out_sr;

    // FIFO state
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf_q;

    // Qualified TAP strobes
    logic cap_act;
    logic shf_act;
    logic upd_act;

    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;

    always_comb begin
        cap_act   = ir_is_user && capture_dr;
        shf_act   = ir_is_user && shift_dr;
        upd_act   = ir_is_user && update_dr;

        fifo_full = (count == CNT_FULL);
        pop       = (count != '0) && inbound_ready;
        push_req  = upd_act && (bit_cnt == BYTE_LEN);
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the byte in that case.
        push_ok   = push_req && (!fifo_full || pop);
        drop      = push_req && fifo_full && !pop;
    end

    // Input deserializer
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            in_sr   <= '0;
            bit_cnt <= '0;
        end else if (cap_act) begin
            bit_cnt <= '0;
        end else if (shf_act) begin
            in_sr <= {tdi, in_sr[7:1]};
            // Saturate so long scans never wrap back to a byte-sized count.
            if (bit_cnt != BIT_MAX) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Result serializer
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            out_sr <= '0;
        end else if (cap_act) begin
            out_sr <= result_valid ? result : '0;
        end else if (shf_act) begin
            out_sr <= {1'b0, out_sr[RESULT_WIDTH-1:1]};
        end
    end

    // Inbound FIFO
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= in_sr;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push_ok) begin
                count <= count - CNT_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign tdo           = out_sr[0];
    assign inbound_valid = (count != '0);
    assign inbound_data  = mem[rd_ptr];
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_bscan_byte_bridge.sv
module tb_bscan_byte_bridge;

    localparam int RW = 32;
    localparam int D  = 4;

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          tdi = 1'b0;
    logic          tdo;
    logic          ir_is_user = 1'b0;
    logic          capture_dr = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          inbound_valid;
    logic          inbound_ready = 1'b0;
    logic [7:0]    inbound_data;
    logic          result_valid = 1'b0;
    logic [RW-1:0] result = '0;
    logic          overflow;

    bscan_byte_bridge #(.RESULT_WIDTH(RW), .FIFO_DEPTH(D)) dut (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo),
        .ir_is_user(ir_is_user), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr),
        .inbound_valid(inbound_valid), .inbound_ready(inbound_ready),
        .inbound_data(inbound_data), .result_valid(result_valid),
        .result(result), .overflow(overflow)
    );

    always #5 tck = ~tck;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: byte queue, bits seen since the last capture,
    // latched result value and number of shifts since capture.
    logic [7:0]    mq[$];
    logic          mbits[$];
    int            m_nshift;
    logic          m_ovf;
    logic [RW-1:0] m_rval;
    int            m_k;

    function automatic void model_reset();
        mq.delete();
        mbits.delete();
        m_nshift = 0;
        m_ovf    = 1'b0;
        m_rval   = '0;
        m_k      = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the same edge, outputs compared 1ns later.
    task automatic cyc();
        bit         act;
        bit         do_pop;
        logic [7:0] b;
        act    = ir_is_user;
        do_pop = (mq.size() != 0) && inbound_ready;
        @(posedge tck);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (act && capture_dr) begin
                mbits.delete();
                m_nshift = 0;
                m_rval   = result_valid ? result : '0;
                m_k      = 0;
            end
            if (act && shift_dr) begin
                mbits.push_back(tdi);
                if (mbits.size() > 8) void'(mbits.pop_front());
                m_nshift++;
                m_k++;
            end
            if (act && update_dr && m_nshift == 8) begin
                b = '0;
                for (int i = 0; i < 8; i++) b = b | (8'(mbits[i]) << i);
                if (mq.size() < D) mq.push_back(b);
                else m_ovf = 1'b1;
            end
        end
        #1;
        chk("tdo", 32'(tdo), (m_k < RW) ? 32'(m_rval[m_k]) : 32'd0);
        chk("inbound_valid", 32'(inbound_valid), 32'(mq.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("inbound_data", 32'(inbound_data), 32'(mq[0]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ir_is_user = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        inbound_ready = 1'b0; tdi = 1'b0;
        cyc();
        cyc();
        chk("reset_data", 32'(inbound_data), 32'd0);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic scan(input logic [31:0] data, input int nbits, input bit act);
        ir_is_user = act;
        capture_dr = 1'b1; cyc(); capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tdi = data[i];
            cyc();
        end
        shift_dr = 1'b0; tdi = 1'b0;
        update_dr = 1'b1; cyc(); update_dr = 1'b0;
        ir_is_user = 1'b1;
    endtask

    task automatic drain_expect(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, 32'(inbound_valid), 32'd1);
        chk({name, "_data"}, 32'(inbound_data), 32'(exp));
        inbound_ready = 1'b1; cyc(); inbound_ready = 1'b0;
    endtask

    task automatic readback(input bit rv, input logic [RW-1:0] r, output logic [RW-1:0] got);
        ir_is_user = 1'b1;
        result_valid = rv; result = r;
        capture_dr = 1'b1; cyc(); capture_dr = 1'b0;
        // Result must be latched at capture, not followed afterwards.
        result = RW'($urandom); result_valid = 1'b1;
        got[0] = tdo;
        shift_dr = 1'b1; tdi = 1'b0;
        for (int i = 1; i < RW; i++) begin
            cyc();
            got[i] = tdo;
        end
        cyc();
        shift_dr = 1'b0;
        update_dr = 1'b1; cyc(); update_dr = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          act;
        bit          exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];
    logic [RW-1:0] got;

    initial begin
        vecs[0] = '{32'h0000_005E,  8, 1'b1, 1'b1, 8'h5E};
        vecs[1] = '{32'h0000_0076,  8, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{32'h0000_007F,  7, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{32'h0000_01FF,  9, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{32'h0000_003C,  8, 1'b1, 1'b1, 8'h3C};
        vecs[5] = '{32'h00A5_5A3C, 24, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{32'h0000_0000,  8, 1'b1, 1'b1, 8'h00};
        vecs[7] = '{32'h0000_0081,  8, 1'b1, 1'b1, 8'h81};

        model_reset();
        do_reset();
        chk("reset_tdo", 32'(tdo), 32'd0);
        chk("reset_valid", 32'(inbound_valid), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);

        // Single scans from an empty FIFO, held with ready low, then popped.
        foreach (vecs[v]) begin
            scan(vecs[v].data, vecs[v].nbits, vecs[v].act);
            cyc(); cyc();
            chk("tbl_valid", 32'(inbound_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) chk("tbl_data", 32'(inbound_data), 32'(vecs[v].exp_data));
            chk("tbl_ovf", 32'(overflow), 32'd0);
            inbound_ready = 1'b1; cyc(); inbound_ready = 1'b0;
            chk("tbl_drained", 32'(inbound_valid), 32'd0);
        end

        // Result readback
        readback(1'b0, 32'hDEAD_BEEF, got);
        chk("rb_invalid", 32'(got), 32'd0);
        chk("rb_invalid_nopush", 32'(inbound_valid), 32'd0);
        readback(1'b1, 32'h0000_0A2B, got);
        chk("rb_valid", 32'(got), 32'h0000_0A2B);
        chk("rb_valid_nopush", 32'(inbound_valid), 32'd0);

        // Malformed scans, then a good one
        scan(32'h7F, 7, 1'b1);
        scan(32'h1AA, 9, 1'b1);
        chk("bad_len_valid", 32'(inbound_valid), 32'd0);
        scan(32'h76, 8, 1'b1);
        cyc();
        drain_expect("after_bad", 8'h76);
        chk("after_bad_empty", 32'(inbound_valid), 32'd0);

        // Full FIFO with pop and push in the update cycle
        scan(32'h11, 8, 1'b1);
        scan(32'h22, 8, 1'b1);
        scan(32'h33, 8, 1'b1);
        scan(32'h44, 8, 1'b1);
        ir_is_user = 1'b1;
        capture_dr = 1'b1; cyc(); capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tdi = (8'h55 >> i) & 1'b1;
            cyc();
        end
        shift_dr = 1'b0; tdi = 1'b0;
        update_dr = 1'b1; inbound_ready = 1'b1; cyc();
        update_dr = 1'b0; inbound_ready = 1'b0;
        cyc();
        chk("same_cycle_ovf", 32'(overflow), 32'd0);
        drain_expect("same_cycle_0", 8'h22);
        drain_expect("same_cycle_1", 8'h33);
        drain_expect("same_cycle_2", 8'h44);
        drain_expect("same_cycle_3", 8'h55);
        chk("same_cycle_empty", 32'(inbound_valid), 32'd0);

        // Overflow on the fifth byte
        scan(32'h3E, 8, 1'b1);
        scan(32'h3C, 8, 1'b1);
        scan(32'h5E, 8, 1'b1);
        scan(32'h76, 8, 1'b1);
        chk("ovf_before", 32'(overflow), 32'd0);
        scan(32'h0A, 8, 1'b1);
        chk("ovf_after", 32'(overflow), 32'd1);
        drain_expect("ovf_0", 8'h3E);
        drain_expect("ovf_1", 8'h3C);
        drain_expect("ovf_2", 8'h5E);
        drain_expect("ovf_3", 8'h76);
        chk("ovf_empty", 32'(inbound_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a scan
        scan(32'h99, 8, 1'b1);
        ir_is_user = 1'b1;
        result_valid = 1'b1; result = 32'hFFFF_FFFF;
        capture_dr = 1'b1; cyc(); capture_dr = 1'b0;
        shift_dr = 1'b1; tdi = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        shift_dr = 1'b0; tdi = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tdo", 32'(tdo), 32'd0);
        chk("rst_async_ovf", 32'(overflow), 32'd0);
        chk("rst_async_valid", 32'(inbound_valid), 32'd0);
        do_reset();
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        scan(32'h5E, 8, 1'b0);
        scan(32'h3C, 8, 1'b1);
        cyc();
        drain_expect("rst_only", 8'h3C);
        chk("rst_empty", 32'(inbound_valid), 32'd0);

        // Randomized scans against the model
        for (int s = 0; s < 60; s++) begin
            int nb;
            int pick;
            pick = $urandom_range(0, 9);
            nb = (pick < 6) ? 8 : (pick == 6) ? 7 : (pick == 7) ? 9 : (pick == 8) ? 24 : 16;
            ir_is_user = ($urandom_range(0, 7) != 0);
            result_valid = $urandom_range(0, 1);
            result = RW'($urandom);
            inbound_ready = ($urandom_range(0, 3) == 0);
            capture_dr = 1'b1; cyc(); capture_dr = 1'b0;
            shift_dr = 1'b1;
            for (int i = 0; i < nb; i++) begin
                tdi = $urandom_range(0, 1);
                inbound_ready = ($urandom_range(0, 3) == 0);
                cyc();
            end
            shift_dr = 1'b0; tdi = 1'b0;
            inbound_ready = ($urandom_range(0, 3) == 0);
            update_dr = 1'b1; cyc(); update_dr = 1'b0;
            for (int i = 0; i < $urandom_range(0, 3); i++) begin
                inbound_ready = ($urandom_range(0, 1) == 0);
                cyc();
            end
        end
        inbound_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) cyc();
        chk("final_empty", 32'(inbound_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
